// File: rtl/fp_result_packer.sv
// fp_result_packer: packs the FP adder's unpacked result into a binary32 word,
// or narrows it to binary16 with RNE/truncate rounding. Packed words and flags
// are queued in a small FIFO. Sticky exception flags accumulate for status.
module fp_result_packer #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode_fp,
  input  logic          round_mode,
  input  logic          result_sign,
  input  logic [7:0]    result_exp,
  input  logic [22:0]   result_mant,
  input  logic          overflow,
  input  logic          underflow,
  input  logic          inexact,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [2:0]    out_flags,
  output logic [2:0]    sticky_flags,
  input  logic          flag_clear,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Packing results (combinational on the inputs)
  logic [31:0] pack_data;
  logic [2:0]  pack_flags;

  // Half-precision working fields
  logic [4:0]  half_exp;
  logic [9:0]  half_mant;
  logic [10:0] half_sum;
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_inc;

  // FIFO state
  logic [34:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [2:0]    sticky_reg, sticky_next;
  logic          push;
  logic          pop;

  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Gate the head with out_valid so stale storage (e.g. after reset) never shows
  assign out_data     = out_valid ? mem[rd_ptr_reg][31:0]  : 32'd0;
  assign out_flags    = out_valid ? mem[rd_ptr_reg][34:32] : 3'd0;
  assign count        = count_reg;
  assign sticky_flags = sticky_reg;

  // Pack the incoming result into binary32 or binary16 and derive its flags
  always_comb begin
    pack_data  = 32'd0;
    pack_flags = {overflow, underflow, inexact};
    // exp-112 fits in 5 bits over the normal half range 113..142, so only the
    // low exponent bits are needed: (exp - 112) mod 32 == exp[4:0] - 16.
    half_exp   = result_exp[4:0] - 5'd16;
    half_mant  = result_mant[22:13];
    guard_bit  = result_mant[12];
    sticky_bit = |result_mant[11:0];
    round_inc  = !round_mode && guard_bit && (sticky_bit || half_mant[0]);
    half_sum   = {1'b0, half_mant} + {10'd0, round_inc};

    if (mode_fp) begin
      if (result_exp == 8'hFF) begin
        pack_data     = {result_sign, 8'hFF, 23'd0};
        pack_flags[2] = 1'b1;
      end else begin
        pack_data = {result_sign, result_exp, result_mant};
      end
    end else begin
      if (result_exp == 8'd0) begin
        pack_data = {16'd0, result_sign, 15'd0};
      end else if (result_exp <= 8'd112) begin
        // Below the half normal range: flush to signed zero
        pack_data     = {16'd0, result_sign, 15'd0};
        pack_flags[1] = 1'b1;
        pack_flags[0] = 1'b1;
      end else if (result_exp >= 8'd143) begin
        pack_data     = {16'd0, result_sign, 5'h1F, 10'd0};
        pack_flags[2] = 1'b1;
      end else begin
        pack_flags[0] = pack_flags[0] | guard_bit | sticky_bit;
        if (half_sum[10]) begin
          // Mantissa rolled over: bump the exponent; 31 encodes infinity
          pack_data = {16'd0, result_sign, half_exp + 5'd1, 10'd0};
          if (half_exp == 5'd30) begin
            pack_flags[2] = 1'b1;
          end
        end else begin
          pack_data = {16'd0, result_sign, half_exp, half_sum[9:0]};
        end
      end
    end
  end

  // Next-state for pointers, occupancy and sticky flags
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    sticky_next = sticky_reg;

    if (push) begin
      wr_ptr_next = (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // A clear in the same cycle as a push keeps the pushed flags
    if (flag_clear) begin
      sticky_next = push ? pack_flags : 3'd0;
    end else if (push) begin
      sticky_next = sticky_reg | pack_flags;
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      sticky_reg <= 3'd0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      sticky_reg <= sticky_next;
    end
  end

  // FIFO storage: write the packed word and flags at push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {pack_flags, pack_data};
    end
  end

endmodule

// File: tb/tb_fp_result_packer.sv
// tb_fp_result_packer: directed table-driven bench for fp_result_packer.
module tb_fp_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        mode_fp;
  logic        round_mode;
  logic        result_sign;
  logic [7:0]  result_exp;
  logic [22:0] result_mant;
  logic        overflow;
  logic        underflow;
  logic        inexact;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;
  logic [2:0]  sticky_flags;
  logic        flag_clear;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_sticky;

  always #5 clk = ~clk;

  fp_result_packer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode_fp(mode_fp), .round_mode(round_mode),
    .result_sign(result_sign), .result_exp(result_exp), .result_mant(result_mant),
    .overflow(overflow), .underflow(underflow), .inexact(inexact),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .flag_clear(flag_clear),
    .count(count)
  );

  typedef struct {
    logic        mode;
    logic        rm;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
    logic [2:0]  up;
    logic [31:0] data;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic m, input logic r, input logic s, input logic [7:0] e,
                       input logic [22:0] mt, input logic [2:0] up);
    mode_fp = m; round_mode = r; result_sign = s; result_exp = e; result_mant = mt;
    overflow = up[2]; underflow = up[1]; inexact = up[0];
  endtask

  initial begin
    // mode rm sign exp mant upstream | data flags
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd127, 23'h000000, 3'b000, 32'h3F800000, 3'b000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'd255, 23'h000123, 3'b000, 32'hFF800000, 3'b100};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h80,  23'h400000, 3'b001, 32'h40400000, 3'b001};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd127, 23'h000000, 3'b000, 32'h00003C00, 3'b000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd127, 23'h7FF000, 3'b000, 32'h00004000, 3'b001};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'd127, 23'h7FF000, 3'b000, 32'h00003FFF, 3'b001};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'd143, 23'h000000, 3'b000, 32'h0000FC00, 3'b100};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd100, 23'h000005, 3'b000, 32'h00000000, 3'b011};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'd0,   23'h000123, 3'b010, 32'h00008000, 3'b010};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd142, 23'h7FF000, 3'b000, 32'h00007C00, 3'b101};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'd127, 23'h001000, 3'b000, 32'h00003C00, 3'b001};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd127, 23'h003000, 3'b000, 32'h00003C02, 3'b001};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'd113, 23'h000000, 3'b000, 32'h00000400, 3'b000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'd112, 23'h000000, 3'b000, 32'h00000000, 3'b011};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 8'd130, 23'h400000, 3'b000, 32'h0000CA00, 3'b000};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flag_clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 23'd0, 3'b000);
    exp_sticky = 3'b000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven single-word transactions with immediate pop
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].mode, vecs[i].rm, vecs[i].sign, vecs[i].exp, vecs[i].mant, vecs[i].up);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      exp_sticky = exp_sticky | vecs[i].flags;
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_data", i), out_data, vecs[i].data);
      check($sformatf("v%0d_flags", i), 32'(out_flags), 32'(vecs[i].flags));
      check($sformatf("v%0d_sticky", i), 32'(sticky_flags), 32'(exp_sticky));
      $display("vec %0d: data=%h flags=%b sticky=%b", i, out_data, out_flags, sticky_flags);
      @(negedge clk);
      check($sformatf("v%0d_count_after_pop", i), 32'(count), 32'd0);
    end
    check("sticky_all", 32'(sticky_flags), 32'b111);

    // Clear pulse with no push
    flag_clear = 1'b1;
    @(negedge clk);
    flag_clear = 1'b0;
    check("sticky_cleared", 32'(sticky_flags), 32'd0);
    $display("flag_clear: sticky=%b", sticky_flags);

    // Fill to full with out_ready low; third word must be refused
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h80, 23'h00000A, 3'b000);
    in_valid = 1'b1;
    @(negedge clk);
    check("fill1_count", 32'(count), 32'd1);
    check("fill1_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 8'h80, 23'h00000B, 3'b000);
    @(negedge clk);
    check("fill2_count", 32'(count), 32'd2);
    check("fill2_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'h80, 23'h00000C, 3'b000);
    @(negedge clk);
    check("fill3_count", 32'(count), 32'd2);
    check("fill3_head", out_data, 32'h4000000A);
    $display("full: count=%0d head=%h", count, out_data);
    // Pop while full with C still offered: no push-through
    out_ready = 1'b1;
    @(negedge clk);
    check("pop1_count", 32'(count), 32'd1);
    check("pop1_head", out_data, 32'h4000000B);
    check("pop1_in_ready", 32'(in_ready), 32'd1);
    // Simultaneous push of C and pop of B
    @(negedge clk);
    in_valid = 1'b0;
    check("pushpop_count", 32'(count), 32'd1);
    check("pushpop_head", out_data, 32'h4000000C);
    @(negedge clk);
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
    $display("drain: count=%0d", count);

    // Reset mid-stream with two entries held
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'd255, 23'h000000, 3'b000);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd2);
    check("pre_rst_sticky", 32'(sticky_flags), 32'b100);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sticky", 32'(sticky_flags), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_data", out_data, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stale_valid_%0d", c), 32'(out_valid), 32'd0);
    end
    $display("mid reset: count=%0d valid=%b", count, out_valid);

    // Clear coincident with a push carrying ovf keeps the new flag
    drive(1'b0, 1'b0, 1'b0, 8'd127, 23'h000000, 3'b001);
    in_valid = 1'b1;
    @(negedge clk);
    check("pre_clr_sticky", 32'(sticky_flags), 32'b001);
    drive(1'b1, 1'b0, 1'b0, 8'd255, 23'h000000, 3'b000);
    flag_clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flag_clear = 1'b0;
    check("clr_push_sticky", 32'(sticky_flags), 32'b100);
    check("clr_push_data", out_data, 32'h7F800000);
    $display("clear+push: sticky=%b data=%h", sticky_flags, out_data);
    repeat (2) @(negedge clk);
    check("final_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_result_packer.md
Name: fp_result_packer

Overview:
- Stage directly downstream of the FP adder/subtractor.
- Consumes its unpacked result (sign, single-biased 8-bit exponent, 23-bit mantissa, overflow/underflow/inexact) and packs it into an IEEE-754 word: binary32, or binary16 with round-to-nearest-even narrowing.
- Packed words and per-result flags are buffered in a small FIFO with valid/ready handshakes on both sides.
- Sticky exception flags accumulate for the status register.

Parameters:
- DEPTH, 2, number of FIFO entries (power of two, >= 2).
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  packer can accept this cycle
- mode_fp  in  1  0=half, 1=single
- round_mode  in  1  0=round-to-nearest-even, 1=truncate (half narrowing only)
- result_sign  in  1  sign
- result_exp  in  8  exponent, bias 127 in both modes
- result_mant  in  23  fraction, no hidden bit
- overflow  in  1  upstream overflow flag
- underflow  in  1  upstream underflow flag
- inexact  in  1  upstream inexact flag
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  32  packed word; half results in [15:0], [31:16]=0
- out_flags  out  3  {ovf,unf,inx} of head entry
- sticky_flags  out  3  accumulated {ovf,unf,inx}
- flag_clear  in  1  clears sticky_flags
- count  out  CW  FIFO occupancy

Behaviour:
- Reset (rst=0 at posedge):
  - count=0, out_valid=0, out_data=0, out_flags=0, sticky_flags=0.
  - FIFO pointers go to 0 and any in-flight entries are discarded.
  - in_ready=1 in the first cycle after reset is released.
- Handshakes:
  - Push when in_valid&&in_ready.
  - Pop when out_valid&&out_ready.
  - in_ready = (count!=DEPTH). No push-through when full, even if a pop occurs that cycle.
  - out_valid = (count!=0).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Latency: a word pushed into an empty FIFO appears at out_valid/out_data on the next cycle.
  - out_data/out_flags hold steady while out_valid&&!out_ready.
- Packing is combinational on the inputs and is stored at push.
- Single mode (mode_fp=1):
  - exp==255: data={sign,8'hFF,23'b0}, ovf forced 1.
  - Otherwise data={sign,exp,mant}.
  - Flags pass through unchanged.
- Half mode (mode_fp=0):
  - exp==0: data={16'b0,sign,15'b0}; flags pass through.
  - 1<=exp<=112 (below half normal range): flush to signed zero; unf=1, inx=1.
  - exp>=143: signed infinity {sign,5'h1F,10'b0}; ovf=1.
  - 113<=exp<=142: he=exp-112 (5 bits), hm=mant[22:13].
  - Rounding fields: guard g=mant[12], sticky s=|mant[11:0].
  - inx |= g|s in both rounding modes.
  - RNE: increment when g&&(s||hm[0]). Truncate: never increment.
  - Increment carry out of hm: hm=0, he+=1. If he becomes 31, result is infinity and ovf=1.
  - data={16'b0,sign,he,hm}.
- Flags:
  - out_flags = upstream flags OR packing-generated flags.
  - Sticky update each cycle:
    - flag_clear=1 with no push: sticky=0.
    - flag_clear=1 with push: sticky=pushed flags only.
    - flag_clear=0 with push: sticky|=pushed flags.
    - flag_clear=0 with no push: hold.
  - Pops never affect sticky_flags.
- Inputs are ignored when in_valid=0 or in_ready=0.

Test Plan:
- Single 1.0 (sign0, exp 127, mant 0), out_ready=1 -> next cycle out_valid=1, out_data=32'h3F800000, out_flags=0, count returns to 0 after pop.
- Half 1.0 (exp 127, mant 0) -> out_data=32'h00003C00. Half with exp 127, mant 23'h7FF000, RNE -> 32'h00004000, out_flags=3'b001. Same input with truncate -> 32'h00003FFF, inx=1.
- Half exp 143, sign1 -> 32'h0000FC00, out_flags=3'b100. Half exp 100, mant 5 -> 32'h00000000, out_flags=3'b011. Sticky then reads 3'b111; flag_clear pulse -> 3'b000.
- DEPTH=2, out_ready=0, three back-to-back valid pushes:
  - in_ready drops after the 2nd accept; count=2; the 3rd word is not accepted.
  - Raise out_ready: words emerge in order with no duplication or loss.
  - Simultaneous push/pop holds count=1.
- Assert rst=0 with count=2 mid-stream -> next cycle count=0, out_valid=0, sticky_flags=0, in_ready=1. The stale entries never appear on out_data.
- flag_clear asserted in the same cycle as a push carrying ovf -> sticky_flags=3'b100 afterward (clear does not drop the new flag).
